// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: accepts one HD44780 command word per CPU store, queues it in a
// one-deep pending slot and plays it onto the LCD bus with setup / EN pulse / hold /
// execution-wait timing. Busy and sticky overrun are exported for CPU readback.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-low reset
//   i_cmd_valid  one-cycle command write strobe
//   i_cmd_data   command word: [31] ON, [9] RS, [8] RW (ignored), [7:0] DATA
//   o_lcd_on     LCD power/backlight
//   o_lcd_en     LCD enable strobe
//   o_lcd_rs     register select
//   o_lcd_rw     read/write, always 0
//   o_lcd_data   LCD data bus
//   o_busy       command in flight or pending
//   o_status     {busy, overrun, 20'b0, RS, 1'b0, DATA}
module lcd_cmd_sequencer #(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN_HIGH   = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  input  logic [31:0] i_cmd_data,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic [31:0] o_status
);

  // Counter reload values: a state lasting T cycles counts T-1 down to 0.
  localparam logic [CNT_W-1:0] SetupLd = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EnLd    = CNT_W'(T_EN_HIGH - 1);
  localparam logic [CNT_W-1:0] HoldLd  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] ExecLd  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LongLd  = CNT_W'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StHold, StWait} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Command records are packed as {ON, RS, DATA[7:0]}.
  logic [9:0]       cmd_q, cmd_d;
  logic [9:0]       pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             overrun_q, overrun_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;

  logic [9:0] incoming;
  logic       last_cycle;
  logic       wait_final;
  logic       is_long;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{i_cmd_data[30:10], i_cmd_data[8]};

  assign incoming   = {i_cmd_data[31], i_cmd_data[9], i_cmd_data[7:0]};
  assign last_cycle = (cnt_q == '0);
  assign wait_final = (state_q == StWait) && last_cycle;
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign is_long    = !cmd_q[8] && (cmd_q[7:2] == 6'd0) && (cmd_q[7:0] != 8'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          cmd_d   = incoming;
          state_d = StSetup;
          cnt_d   = SetupLd;
        end
      end
      StSetup: begin
        if (last_cycle) begin
          state_d = StEnHi;
          cnt_d   = EnLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StEnHi: begin
        if (last_cycle) begin
          state_d = StHold;
          cnt_d   = HoldLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (last_cycle) begin
          state_d = StWait;
          cnt_d   = is_long ? LongLd : ExecLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWait: begin
        if (last_cycle) begin
          if (pend_full_q) begin
            // Pending launches; a simultaneous write refills the slot.
            cmd_d       = pend_q;
            state_d     = StSetup;
            cnt_d       = SetupLd;
            pend_full_d = i_cmd_valid;
            if (i_cmd_valid) begin
              pend_d = incoming;
            end
          end else if (i_cmd_valid) begin
            cmd_d   = incoming;
            state_d = StSetup;
            cnt_d   = SetupLd;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Writes arriving mid-command queue up; the WAIT final cycle is handled above.
    if ((state_q != StIdle) && i_cmd_valid && !wait_final) begin
      if (!pend_full_q) begin
        pend_d      = incoming;
        pend_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    en_d   = (state_d == StEnHi);
    busy_d = (state_d != StIdle) || pend_full_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cmd_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
    end
  end

  assign o_lcd_on   = cmd_q[9];
  assign o_lcd_rs   = cmd_q[8];
  assign o_lcd_data = cmd_q[7:0];
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_busy     = busy_q;
  assign o_status   = {busy_q, overrun_q, 20'd0, cmd_q[8], 1'b0, cmd_q[7:0]};

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer with shortened timing
// (T_SETUP=2, T_EN_HIGH=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=30).
module tb_lcd_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;
  logic        busy;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  lcd_cmd_sequencer #(
    .T_SETUP    (2),
    .T_EN_HIGH  (4),
    .T_HOLD     (2),
    .T_EXEC     (10),
    .T_EXEC_LONG(30),
    .CNT_W      (17)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_cmd_valid(cmd_valid),
    .i_cmd_data (cmd_data),
    .o_lcd_on   (lcd_on),
    .o_lcd_en   (lcd_en),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_data (lcd_data),
    .o_busy     (busy),
    .o_status   (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; sampling happens 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch c0 from IDLE, optionally inject c1 in cycle k1 and c2 in cycle k2
  // (cycle k = interval after edge N+k, N being the edge that samples c0).
  // nl commands launch back to back, each occupying per cycles.
  task automatic run_seq(input string tag, input logic [31:0] c0,
                         input int k1, input logic [31:0] c1,
                         input int k2, input logic [31:0] c2,
                         input int nl, input int per,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [31:0] exp_status);
    logic [7:0] dexp [3];
    dexp[0] = d0;
    dexp[1] = d1;
    dexp[2] = d2;
    cmd_valid = 1'b1;
    cmd_data  = c0;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= nl * per + 1; k++) begin
      int  idx;
      int  off;
      logic en_exp;
      if (k == k1) begin
        cmd_valid = 1'b1;
        cmd_data  = c1;
      end else if (k == k2) begin
        cmd_valid = 1'b1;
        cmd_data  = c2;
      end else begin
        cmd_valid = 1'b0;
      end
      idx = (k - 1) / per;
      if (idx > nl - 1) idx = nl - 1;
      off = k - idx * per;
      en_exp = (k <= nl * per) && (off >= 3) && (off <= 6);
      chk({tag, "_en"}, {31'd0, lcd_en}, {31'd0, en_exp});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, k <= nl * per});
      chk({tag, "_data"}, {24'd0, lcd_data}, {24'd0, dexp[idx]});
      chk({tag, "_rw"}, {31'd0, lcd_rw}, 32'd0);
      if (k == 1) begin
        chk({tag, "_on"}, {31'd0, lcd_on}, {31'd0, c0[31]});
        chk({tag, "_rs"}, {31'd0, lcd_rs}, {31'd0, c0[9]});
      end
      step();
    end
    cmd_valid = 1'b0;
    chk({tag, "_status"}, status, exp_status);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
    step();
    step();
    chk("rst_en", {31'd0, lcd_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_on", {31'd0, lcd_on}, 32'd0);
    chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_status", status, 32'd0);
    rst_n = 1'b1;
    step();

    // Single write: EN in N+3..N+6, busy N+1..N+18.
    run_seq("single", 32'h8000_0241, 0, 32'd0, 0, 32'd0, 1, 18,
            8'h41, 8'h41, 8'h41, 32'h0000_0241);
    // Clear display uses the long wait (38 busy cycles); entry mode set uses the short one.
    run_seq("clear", 32'h8000_0001, 0, 32'd0, 0, 32'd0, 1, 38,
            8'h01, 8'h01, 8'h01, 32'h0000_0001);
    run_seq("entry", 32'h8000_0006, 0, 32'd0, 0, 32'd0, 1, 18,
            8'h06, 8'h06, 8'h06, 32'h0000_0006);
    // Second write during EN_HI is queued and follows with no gap.
    run_seq("b2b", 32'h8000_0230, 3, 32'h8000_0231, 0, 32'd0, 2, 18,
            8'h30, 8'h31, 8'h31, 32'h0000_0231);
    // Write in the WAIT final cycle with empty slot: bypass launch.
    run_seq("wfin_empty", 32'h8000_0241, 18, 32'h8000_0242, 0, 32'd0, 2, 18,
            8'h41, 8'h42, 8'h42, 32'h0000_0242);
    // Write in the WAIT final cycle with full slot: pending launches, new one queued.
    run_seq("wfin_full", 32'h8000_0241, 3, 32'h8000_0242, 18, 32'h8000_0243, 3, 18,
            8'h41, 8'h42, 8'h43, 32'h0000_0243);
    // Third write while slot is full is dropped and sets sticky overrun.
    run_seq("ovr", 32'h8000_0241, 3, 32'h8000_0252, 5, 32'h8000_0263, 2, 18,
            8'h41, 8'h52, 8'h52, 32'h4000_0252);
    step();
    chk("ovr_sticky", status, 32'h4000_0252);

    // Reset during EN_HI aborts immediately and clears overrun.
    cmd_valid = 1'b1;
    cmd_data  = 32'h8000_0241;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_en_before", {31'd0, lcd_en}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_en", {31'd0, lcd_en}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_status", status, 32'd0);
    chk("mid_rst_on", {31'd0, lcd_on}, 32'd0);
    rst_n = 1'b1;
    step();
    run_seq("after_rst", 32'h8000_0248, 0, 32'd0, 0, 32'd0, 1, 18,
            8'h48, 8'h48, 8'h48, 32'h0000_0248);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Sits directly downstream of the load/store unit's LCD control register, between the CPU memory-mapped write path and the HD44780-compatible character LCD pins.
- Software writes one command word per store. The block queues it, then generates the LCD bus timing: address setup, EN pulse, hold, and command execution wait.
- Busy/overrun status is exported for CPU readback through the LCD register read mux.

Parameters:
- T_SETUP, 2, cycles RS/DATA stable before EN rises (t_AS).
- T_EN_HIGH, 12, cycles EN held high (t_PW ≥230 ns at 50 MHz).
- T_HOLD, 2, cycles RS/DATA held after EN falls (t_H).
- T_EXEC, 2000, post-command wait cycles, normal command (40 us at 50 MHz).
- T_EXEC_LONG, 82000, post-command wait cycles, clear/home (1.64 ms).
- CNT_W, 17, phase counter width; must hold the largest T_* value.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-low reset
- i_cmd_valid  in  1  one-cycle write strobe (LCD enable & LSU write enable)
- i_cmd_data  in  32  command word: [31] ON, [9] RS, [8] RW (ignored), [7:0] DATA; other bits ignored
- o_lcd_on  out  1  LCD power/backlight
- o_lcd_en  out  1  LCD enable strobe
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write; tied 0 (write-only)
- o_lcd_data  out  8  LCD data bus
- o_busy  out  1  command in flight or pending
- o_status  out  32  readback word

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_reset.
- Reset (i_reset=0 at a rising edge):
  - state=IDLE, pending slot empty, counter=0, overrun=0.
  - All outputs 0 on the next cycle.
  - Reset mid-operation aborts the current command immediately; EN is low in the cycle after the reset edge.
- FSM states: IDLE, SETUP, EN_HI, HOLD, WAIT. Each timed state lasts exactly its T_* cycles; the counter reloads on every state entry.
- IDLE + i_cmd_valid:
  - Latch the command.
  - Next cycle: SETUP, with o_lcd_rs/o_lcd_data/o_lcd_on driven from the command and o_lcd_en=0.
- SETUP -> EN_HI: o_lcd_en=1 for T_EN_HIGH cycles.
- EN_HI -> HOLD: EN=0; RS/DATA held.
- HOLD -> WAIT:
  - Wait length is T_EXEC_LONG if RS=0 and DATA[7:2]==0 and DATA!=0 (clear/home); otherwise T_EXEC.
- WAIT final cycle, in priority order:
  - Pending slot full: launch pending into SETUP.
  - Else i_cmd_valid: launch the incoming command into SETUP (bypass).
  - Else: go to IDLE.
- Pending slot (1 deep), fed by i_cmd_valid in any non-IDLE state:
  - Slot empty: store the command.
  - Slot full, and not the WAIT final cycle: discard the command and set sticky overrun.
  - Slot full, WAIT final cycle: the pending command launches and the incoming command fills the slot; no overrun.
- o_lcd_rs, o_lcd_data, o_lcd_on: hold the last launched command's values through IDLE until the next launch.
- o_busy = (state!=IDLE) | pending_full. Registered, so it rises the cycle after acceptance.
- o_status layout:
  - [31] busy, [30] overrun, [29:10] 0
  - [9] RS and [7:0] DATA of the last launched command
  - [8] 0
- Overrun clears only on reset.
- o_lcd_rw is always 0. The RW bit of i_cmd_data is ignored.
- Total busy time for a single command = T_SETUP + T_EN_HIGH + T_HOLD + wait.

Test Plan (bench parameters: T_SETUP=2, T_EN_HIGH=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=30):
- Single write 0x8000_0241 with valid at edge N:
  - o_lcd_on=1, o_lcd_rs=1, o_lcd_data=0x41 from N+1.
  - o_lcd_en=1 exactly in cycles N+3..N+6.
  - o_busy high N+1..N+18, low at N+19.
  - o_status=0x0000_0241 after completion.
- Clear display 0x8000_0001: WAIT lasts 30 cycles; o_busy high for 38 cycles. Then 0x8000_0006 uses a 10-cycle WAIT, 18 cycles total.
- Two back-to-back writes 0x8000_0230 then 0x8000_0231 (second during EN_HI):
  - Second EN pulse starts exactly T_SETUP cycles after the first command's WAIT ends.
  - o_busy stays continuously high; overrun=0.
- Three writes during one command: the third is discarded and o_status[30]=1. Only two EN pulses occur, with data of the 1st and 2nd commands.
- Valid in the WAIT final cycle:
  - With the slot empty, the command launches with no IDLE cycle.
  - With the slot full, the pending command launches, the new command is queued, and overrun stays 0.
- i_reset=0 during EN_HI: o_lcd_en=0, o_busy=0, o_status=0 the next cycle. After release, a new write runs with full timing.
